// File: rtl/if_stream_pkg.sv
// if_stream_pkg: tag flag constants, packer FSM encoding and tagged-word width helper.
package if_stream_pkg;
    localparam logic [1:0] FLAG_SOR = 2'b10;
    localparam logic [1:0] FLAG_EOR = 2'b01;
    localparam logic [1:0] FLAG_PAD = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FLUSH, S_DONE} state_t;
    function automatic int tag_width(input int data_width);
        return data_width + 2;
    endfunction
endpackage

// File: rtl/frame_pos_counter.sv
// frame_pos_counter: column/row position within a frame with row-boundary and last-pixel flags.
module frame_pos_counter #(
    parameter int DIM_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             adv_i,
    input  logic [DIM_W-1:0] row_len_i,
    input  logic [DIM_W-1:0] num_rows_i,
    output logic             is_sor_o,
    output logic             is_eor_o,
    output logic             is_last_o
);
    logic [DIM_W-1:0] col_q, row_q;
    assign is_sor_o  = col_q == '0;
    assign is_eor_o  = col_q == row_len_i - DIM_W'(1);
    assign is_last_o = is_eor_o && row_q == num_rows_i - DIM_W'(1);
    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            col_q <= is_eor_o ? '0 : col_q + DIM_W'(1);
            row_q <= is_eor_o ? row_q + DIM_W'(1) : row_q;
        end
    end
endmodule

// File: rtl/if_row_packer.sv
// if_row_packer: tags pixels with SOR/EOR flags and packs PAR_WRITE tagged words per IF FIFO write.
module if_row_packer import if_stream_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 4,
    parameter int DIM_W      = 8
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [DIM_W-1:0]                    cfg_row_len,
    input  logic [DIM_W-1:0]                    cfg_num_rows,
    input  logic                                s_valid,
    input  logic [DATA_WIDTH-1:0]               s_data,
    output logic                                s_ready,
    input  logic                                fifo_full,
    output logic                                fifo_wen,
    output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0] fifo_din,
    output logic                                busy,
    output logic                                done
);
    localparam int TW = tag_width(DATA_WIDTH);
    localparam int SW = PAR_WRITE > 1 ? $clog2(PAR_WRITE) : 1;
    state_t                          state_q;
    logic [DIM_W-1:0]                row_len_q, num_rows_q;
    logic [SW-1:0]                   slot_idx_q, slot_idx_d;
    logic [PAR_WRITE-1:0][TW-1:0]    pack_q, pack_d;
    logic                            pending_q;
    logic                            accept, is_sor, is_eor, is_last, group_end;
    logic [TW-1:0]                   word;
    assign s_ready   = state_q == S_FILL && !pending_q;
    assign accept    = s_ready && s_valid;
    assign fifo_wen  = pending_q && !fifo_full;
    assign fifo_din  = pack_q;
    assign busy      = state_q == S_FILL || state_q == S_FLUSH;
    assign done      = state_q == S_DONE;
    assign word      = {(is_sor ? FLAG_SOR : 2'b00) | (is_eor ? FLAG_EOR : 2'b00), s_data};
    assign group_end = slot_idx_q == SW'(PAR_WRITE - 1) || is_last;
    assign slot_idx_d = accept ? (group_end ? '0 : slot_idx_q + SW'(1)) : slot_idx_q;
    frame_pos_counter #(.DIM_W(DIM_W)) u_pos (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (state_q == S_IDLE),
        .adv_i      (accept),
        .row_len_i  (row_len_q),
        .num_rows_i (num_rows_q),
        .is_sor_o   (is_sor),
        .is_eor_o   (is_eor),
        .is_last_o  (is_last)
    );
    // The last pixel of a frame also pads every later slot so the final group is always full width.
    always_comb begin
        pack_d = pack_q;
        for (int k = 0; k < PAR_WRITE; k++) begin
            if (accept && SW'(k) == slot_idx_q) pack_d[k] = word;
            else if (accept && is_last && SW'(k) > slot_idx_q) pack_d[k] = {FLAG_PAD, DATA_WIDTH'(0)};
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            row_len_q  <= '0;
            num_rows_q <= '0;
            slot_idx_q <= '0;
            pack_q     <= '0;
            pending_q  <= 1'b0;
        end else begin
            pack_q     <= pack_d;
            slot_idx_q <= slot_idx_d;
            pending_q  <= (accept && group_end) ? 1'b1 : (fifo_wen ? 1'b0 : pending_q);
            case (state_q)
                S_IDLE: if (start) begin
                    row_len_q  <= cfg_row_len;
                    num_rows_q <= cfg_num_rows;
                    state_q    <= (cfg_row_len == '0 || cfg_num_rows == '0) ? S_DONE : S_FILL;
                end
                S_FILL:  if (accept && is_last) state_q <= S_FLUSH;
                S_FLUSH: if (!pending_q) state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_row_packer.sv
// tb_if_row_packer: table-driven and randomized frames checked against a queue-based packing model.
module tb_if_row_packer;
    localparam int DW = 8, P = 4, DIMW = 8, TW = DW + 2;
    typedef logic [P*TW-1:0] grp_t;
    typedef struct {
        int rl;
        int nr;
        bit seq;
        int full_pct;
        int valid_pct;
        int hold;
        bit noise;
        int exp_groups;
    } vec_t;
    logic clk = 0, rstn = 0, start = 0, s_valid = 0, fifo_full = 0;
    logic s_ready, fifo_wen, busy, done;
    logic [DIMW-1:0] cfg_row_len = '0, cfg_num_rows = '0;
    logic [DW-1:0] s_data = '0;
    grp_t fifo_din;
    grp_t got_q[$];
    int checks = 0, errors = 0;
    vec_t tbl[10];
    always #5 clk = ~clk;
    if_row_packer #(.DATA_WIDTH(DW), .PAR_WRITE(P), .DIM_W(DIMW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .fifo_full(fifo_full),
        .fifo_wen(fifo_wen), .fifo_din(fifo_din), .busy(busy), .done(done)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_s_ready"}, s_ready, 0);
        chk({tag, "_fifo_wen"}, fifo_wen, 0);
        chk({tag, "_fifo_din"}, fifo_din, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask
    task automatic run_frame(input int rl, input int nr, input bit seq, input int full_pct,
                             input int valid_pct, input int hold, input bit noise);
        logic [DW-1:0] src[$];
        logic [TW-1:0] words[$];
        grp_t exp_q[$];
        grp_t g;
        int len, idx, acc, dn, viol, post;
        bit ds;
        len = rl * nr; idx = 0; acc = 0; dn = 0; viol = 0; post = 0; ds = 0;
        got_q.delete();
        for (int i = 0; i < len; i++) src.push_back(seq ? DW'(i + 1) : DW'($urandom));
        for (int i = 0; i < len; i++) words.push_back({i % rl == 0, i % rl == rl - 1, src[i]});
        while (words.size() % P != 0) words.push_back({2'b11, DW'(0)});
        for (int gi = 0; gi < words.size() / P; gi++) begin
            g = '0;
            for (int k = 0; k < P; k++) g[k*TW +: TW] = words[gi*P + k];
            exp_q.push_back(g);
        end
        for (int c = 0; c < 4000 && post < 3; c++) begin
            @(negedge clk);
            start        = (c == 0) || (noise && !ds && $urandom_range(99) < 10);
            cfg_row_len  = c == 0 ? DIMW'(rl) : DIMW'($urandom);
            cfg_num_rows = c == 0 ? DIMW'(nr) : DIMW'($urandom);
            fifo_full    = (c < hold) || (int'($urandom_range(99)) < full_pct);
            s_valid      = (idx < len) && (int'($urandom_range(99)) < valid_pct);
            s_data       = idx < len ? src[idx] : DW'($urandom);
            #1;
            if (s_valid && s_ready) begin acc++; idx++; end
            if (fifo_wen) begin
                got_q.push_back(fifo_din);
                if (fifo_full || ds) viol++;
            end
            if (ds) post++;
            if (done) begin dn++; ds = 1; if (busy) viol++; end
            if (hold > 0 && c == hold - 1) begin
                chk("hold_accepts", acc, P);
                chk("hold_writes", got_q.size(), 0);
            end
        end
        start = 0; s_valid = 0; fifo_full = 0;
        chk("done_seen", ds, 1);
        chk("done_pulses", dn, 1);
        chk("protocol_viol", viol, 0);
        chk("accepted", acc, len);
        chk("groups", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("group%0d", i), got_q[i], exp_q[i]);
    endtask
    initial begin
        int n;
        tbl[0] = '{4, 2, 1, 0, 100, 0, 0, 2};
        tbl[1] = '{3, 2, 1, 0, 100, 0, 0, 2};
        tbl[2] = '{4, 2, 1, 0, 100, 16, 0, 2};
        tbl[3] = '{1, 3, 1, 0, 100, 0, 0, 1};
        tbl[4] = '{0, 5, 0, 0, 100, 0, 0, 0};
        tbl[5] = '{5, 0, 0, 0, 100, 0, 1, 0};
        tbl[6] = '{7, 3, 0, 30, 70, 0, 1, 6};
        tbl[7] = '{4, 4, 0, 50, 50, 0, 1, 4};
        tbl[8] = '{9, 5, 0, 20, 80, 0, 1, 12};
        tbl[9] = '{255, 2, 0, 10, 90, 0, 1, 128};
        repeat (3) @(negedge clk);
        #1 chk_idle_outputs("reset");
        @(negedge clk) rstn = 1;
        run_frame(4, 2, 1, 0, 100, 0, 0);
        chk("t1_g0", got_q[0], {2'b01, 8'd4, 2'b00, 8'd3, 2'b00, 8'd2, 2'b10, 8'd1});
        chk("t1_g1", got_q[1], {2'b01, 8'd8, 2'b00, 8'd7, 2'b00, 8'd6, 2'b10, 8'd5});
        run_frame(3, 2, 1, 0, 100, 0, 0);
        chk("t2_g0", got_q[0], {2'b10, 8'd4, 2'b01, 8'd3, 2'b00, 8'd2, 2'b10, 8'd1});
        chk("t2_g1", got_q[1], {2'b11, 8'd0, 2'b11, 8'd0, 2'b01, 8'd6, 2'b00, 8'd5});
        run_frame(1, 3, 1, 0, 100, 0, 0);
        chk("t4_g0", got_q[0], {2'b11, 8'd0, 2'b11, 8'd3, 2'b11, 8'd2, 2'b11, 8'd1});
        @(negedge clk);
        start = 1; cfg_row_len = 5; cfg_num_rows = 0;
        @(negedge clk);
        start = 0;
        #1;
        chk("zero_rows_done", done, 1);
        chk("zero_rows_busy", busy, 0);
        chk("zero_rows_wen", fifo_wen, 0);
        @(negedge clk);
        #1 chk("zero_rows_done_once", done, 0);
        @(negedge clk);
        start = 1; cfg_row_len = 4; cfg_num_rows = 2;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            @(negedge clk);
            start = 0; s_valid = 1; s_data = DW'(8'h20 + n);
            #1;
            if (s_ready) n++;
        end
        chk("rst_pre_accepts", n, 2);
        @(negedge clk);
        s_valid = 0; rstn = 0;
        @(negedge clk);
        #1 chk_idle_outputs("midrst");
        rstn = 1;
        run_frame(3, 3, 0, 20, 80, 0, 1);
        foreach (tbl[i]) begin
            run_frame(tbl[i].rl, tbl[i].nr, tbl[i].seq, tbl[i].full_pct, tbl[i].valid_pct,
                      tbl[i].hold, tbl[i].noise);
            chk($sformatf("tbl%0d_count", i), got_q.size(), tbl[i].exp_groups);
        end
        for (int r = 0; r < 6; r++) begin
            int rl, nr;
            rl = int'($urandom_range(1, 12));
            nr = int'($urandom_range(1, 6));
            run_frame(rl, nr, 0, int'($urandom_range(0, 60)), int'($urandom_range(30, 100)), 0, 1);
            chk($sformatf("rand%0d_count", r), got_q.size(), (rl * nr + P - 1) / P);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
